// File: rtl/readreg_hold_stage.sv
// Register-read stage with a one-entry output slot that keeps snooping feedback
// channels while issue stalls, so operands missing at capture can be filled in place.
module readreg_hold_stage #(
    parameter int LANES     = 2,
    parameter int FB_NUM    = 4,
    parameter int PHY_ID_W  = 6,
    parameter int DATA_W    = 32,
    parameter int PAYLOAD_W = 128,
    parameter int CNT_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES-1:0]              in_lane_enable,
    input  logic [LANES*2*PHY_ID_W-1:0]   in_rs_phy,
    input  logic [LANES*2-1:0]            in_need_map,
    input  logic [LANES*2*DATA_W-1:0]     in_alt_value,
    input  logic [LANES*PAYLOAD_W-1:0]    in_payload,
    output logic [LANES*2*PHY_ID_W-1:0]   phyf_id,
    input  logic [LANES*2*DATA_W-1:0]     phyf_data,
    input  logic [LANES*2-1:0]            phyf_data_valid,
    input  logic [FB_NUM-1:0]             fb_enable,
    input  logic [FB_NUM*PHY_ID_W-1:0]    fb_phy_id,
    input  logic [FB_NUM*DATA_W-1:0]      fb_value,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES-1:0]              out_lane_enable,
    output logic [LANES*PAYLOAD_W-1:0]    out_payload,
    output logic [LANES*2*DATA_W-1:0]     out_src_value,
    output logic [LANES*2-1:0]            out_src_loaded,
    output logic [CNT_W-1:0]              stall_cycles
);
    localparam int SRCS = LANES * 2;

    logic                        in_fire;
    logic                        hold;
    logic [SRCS*PHY_ID_W-1:0]    held_rs;
    logic [SRCS*DATA_W-1:0]      cap_value;
    logic [SRCS-1:0]             cap_loaded;
    logic [SRCS*DATA_W-1:0]      snoop_value;
    logic [SRCS-1:0]             snoop_hit;

    assign in_ready = !flush && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign hold     = out_valid && !out_ready && !flush;
    assign phyf_id  = in_rs_phy;

    // Feedback loops run high-to-low so the lowest-index matching channel wins.
    always_comb begin
        cap_value  = '0;
        cap_loaded = '0;
        for (int s = 0; s < SRCS; s++) begin
            if (!in_lane_enable[s/2] || !in_need_map[s]) begin
                cap_value[s*DATA_W +: DATA_W] = in_alt_value[s*DATA_W +: DATA_W];
                cap_loaded[s] = 1'b1;
            end else if (phyf_data_valid[s]) begin
                cap_value[s*DATA_W +: DATA_W] = phyf_data[s*DATA_W +: DATA_W];
                cap_loaded[s] = 1'b1;
            end else begin
                for (int c = FB_NUM - 1; c >= 0; c--) begin
                    if (fb_enable[c] &&
                        fb_phy_id[c*PHY_ID_W +: PHY_ID_W] == in_rs_phy[s*PHY_ID_W +: PHY_ID_W]) begin
                        cap_value[s*DATA_W +: DATA_W] = fb_value[c*DATA_W +: DATA_W];
                        cap_loaded[s] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        snoop_value = '0;
        snoop_hit   = '0;
        for (int s = 0; s < SRCS; s++) begin
            for (int c = FB_NUM - 1; c >= 0; c--) begin
                if (fb_enable[c] &&
                    fb_phy_id[c*PHY_ID_W +: PHY_ID_W] == held_rs[s*PHY_ID_W +: PHY_ID_W]) begin
                    snoop_value[s*DATA_W +: DATA_W] = fb_value[c*DATA_W +: DATA_W];
                    snoop_hit[s] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid       <= 1'b0;
            out_lane_enable <= '0;
            out_payload     <= '0;
            out_src_value   <= '0;
            out_src_loaded  <= '0;
            held_rs         <= '0;
        end else if (flush) begin
            out_valid       <= 1'b0;
            out_lane_enable <= '0;
        end else if (in_fire) begin
            out_valid       <= 1'b1;
            out_lane_enable <= in_lane_enable;
            out_payload     <= in_payload;
            out_src_value   <= cap_value;
            out_src_loaded  <= cap_loaded;
            held_rs         <= in_rs_phy;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else if (hold) begin
            for (int s = 0; s < SRCS; s++) begin
                if (out_lane_enable[s/2] && !out_src_loaded[s] && snoop_hit[s]) begin
                    out_src_value[s*DATA_W +: DATA_W] <= snoop_value[s*DATA_W +: DATA_W];
                    out_src_loaded[s] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (hold && stall_cycles != {CNT_W{1'b1}}) begin
            stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
